// File: rtl/signed_acc_adder.sv
// signed_acc_adder: two-stage signed add/sub/accumulate with saturate/wrap and valid/ready flow control
module signed_acc_adder #(
  parameter int WIDTH     = 8,
  parameter int ACC_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  input  logic [1:0]           op,
  input  logic                 sat_en,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [ACC_WIDTH-1:0] sum,
  output logic                 ovf,
  output logic [ACC_WIDTH-1:0] acc
);
  localparam int EW = ACC_WIDTH + 1;
  logic                 s1_valid_q, s1_valid_d;
  logic [WIDTH-1:0]     s1_a_q, s1_a_d, s1_b_q, s1_b_d;
  logic [1:0]           s1_op_q, s1_op_d;
  logic                 s1_sat_q, s1_sat_d;
  logic                 out_valid_q, out_valid_d;
  logic [ACC_WIDTH-1:0] sum_q, sum_d, acc_q, acc_d;
  logic                 ovf_q, ovf_d;
  logic                 adv1, adv2, of, clr;
  logic [EW-1:0]        ea, eb, eacc, r;
  logic [ACC_WIDTH-1:0] res;
  always_comb begin
    adv2 = !out_valid_q || out_ready;
    adv1 = !s1_valid_q || adv2;
    ea   = {{(EW-WIDTH){s1_a_q[WIDTH-1]}}, s1_a_q};
    eb   = {{(EW-WIDTH){s1_b_q[WIDTH-1]}}, s1_b_q};
    eacc = {acc_q[ACC_WIDTH-1], acc_q};
    r    = s1_op_q == 2'b00 ? ea + eb : s1_op_q == 2'b01 ? ea - eb : eacc + ea;
    // one guard bit: overflow iff the top two bits of the exact result disagree
    of   = r[EW-1] ^ r[EW-2];
    res  = (!of || !s1_sat_q) ? r[ACC_WIDTH-1:0] :
           r[EW-1] ? {1'b1, {(ACC_WIDTH-1){1'b0}}} : {1'b0, {(ACC_WIDTH-1){1'b1}}};
    clr  = s1_op_q == 2'b11;
    s1_valid_d  = adv1 ? in_valid : s1_valid_q;
    s1_a_d      = adv1 ? a : s1_a_q;
    s1_b_d      = adv1 ? b : s1_b_q;
    s1_op_d     = adv1 ? op : s1_op_q;
    s1_sat_d    = adv1 ? sat_en : s1_sat_q;
    out_valid_d = adv2 ? s1_valid_q : out_valid_q;
    sum_d       = sum_q;
    ovf_d       = ovf_q;
    acc_d       = acc_q;
    if (adv2 && s1_valid_q) begin
      sum_d = clr ? '0 : res;
      ovf_d = clr ? 1'b0 : of;
      acc_d = s1_op_q[1] ? (clr ? '0 : res) : acc_q;
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q  <= 1'b0;
      s1_a_q      <= '0;
      s1_b_q      <= '0;
      s1_op_q     <= '0;
      s1_sat_q    <= 1'b0;
      out_valid_q <= 1'b0;
      sum_q       <= '0;
      ovf_q       <= 1'b0;
      acc_q       <= '0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      s1_a_q      <= s1_a_d;
      s1_b_q      <= s1_b_d;
      s1_op_q     <= s1_op_d;
      s1_sat_q    <= s1_sat_d;
      out_valid_q <= out_valid_d;
      sum_q       <= sum_d;
      ovf_q       <= ovf_d;
      acc_q       <= acc_d;
    end
  end
  assign in_ready  = adv1;
  assign out_valid = out_valid_q;
  assign sum       = sum_q;
  assign ovf       = ovf_q;
  assign acc       = acc_q;
endmodule

// File: tb/tb_signed_acc_adder.sv
// tb_signed_acc_adder: directed vectors for signed_acc_adder with WIDTH=8, ACC_WIDTH=9
module tb_signed_acc_adder;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_valid = 1'b0, in_ready;
  logic [7:0] a = '0, b = '0;
  logic [1:0] op = '0;
  logic       sat_en = 1'b0;
  logic       out_valid, out_ready = 1'b1;
  logic [8:0] sum, acc;
  logic       ovf;
  int         vectors = 0, miscompares = 0;

  signed_acc_adder #(.WIDTH(8), .ACC_WIDTH(9)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .op(op), .sat_en(sat_en), .out_valid(out_valid),
    .out_ready(out_ready), .sum(sum), .ovf(ovf), .acc(acc)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [1:0] o, input int x, input int y, input logic s);
    in_valid = v;
    op = o;
    a = x[7:0];
    b = y[7:0];
    sat_en = s;
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic res(input string tag, input int s, input logic o, input int ac);
    chk({tag, "_valid"}, out_valid, 1);
    chk({tag, "_sum"}, $signed(sum), s);
    chk({tag, "_ovf"}, ovf, o);
    chk({tag, "_acc"}, $signed(acc), ac);
  endtask

  initial begin
    int sent, got, c;
    logic stalled;
    logic [8:0] held_sum;
    logic held_ovf;
    logic [3:0] pat;
    // reset state
    repeat (2) tick;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_sum", sum, 0);
    chk("rst_ovf", ovf, 0);
    chk("rst_acc", acc, 0);
    rst_n = 1'b1;
    tick;
    chk("rst_in_ready", in_ready, 1);
    // latency and throughput
    drive(1, 2'b00, 100, 27, 1); tick;
    chk("lat_early", out_valid, 0);
    drive(1, 2'b01, -128, 1, 1); tick;
    res("lat_add", 127, 0, 0);
    drive(0, 2'b00, 0, 0, 1); tick;
    res("lat_sub", -129, 0, 0);
    tick;
    chk("lat_drain", out_valid, 0);
    // saturate
    drive(1, 2'b11, 0, 0, 1); tick;
    drive(1, 2'b10, 127, 0, 1); tick;
    res("sat_clr", 0, 0, 0);
    drive(1, 2'b10, 127, 0, 1); tick;
    res("sat_acc1", 127, 0, 127);
    drive(1, 2'b10, 127, 0, 1); tick;
    res("sat_acc2", 254, 0, 254);
    drive(1, 2'b10, -128, 99, 1); tick;
    res("sat_acc3", 255, 1, 255);
    drive(0, 2'b00, 0, 0, 0); tick;
    res("sat_neg", 127, 0, 127);
    // wrap
    drive(1, 2'b11, 0, 0, 0); tick;
    drive(1, 2'b10, 127, 0, 0); tick;
    res("wrap_clr", 0, 0, 0);
    drive(1, 2'b10, 127, 0, 0); tick;
    res("wrap_acc1", 127, 0, 127);
    drive(1, 2'b10, 127, 0, 0); tick;
    res("wrap_acc2", 254, 0, 254);
    drive(1, 2'b00, -128, -128, 0); tick;
    res("wrap_acc3", -131, 1, -131);
    drive(0, 2'b00, 0, 0, 0); tick;
    res("wrap_add", -256, 0, -131);
    // mixed ops
    drive(1, 2'b11, 0, 0, 0); tick;
    drive(1, 2'b10, 5, 0, 0); tick;
    res("mix_clr0", 0, 0, 0);
    drive(1, 2'b00, 3, 4, 0); tick;
    res("mix_acc5", 5, 0, 5);
    drive(1, 2'b10, -2, 0, 0); tick;
    res("mix_add", 7, 0, 5);
    drive(1, 2'b11, 0, 0, 0); tick;
    res("mix_accm2", 3, 0, 3);
    drive(0, 2'b00, 0, 0, 0); tick;
    res("mix_clr", 0, 0, 0);
    tick;
    chk("mix_drain", out_valid, 0);
    // backpressure: out_ready pattern 1,0,0,1 repeating
    pat = 4'b1001;
    sent = 0; got = 0; c = 0;
    stalled = 1'b0; held_sum = '0; held_ovf = 1'b0;
    while (got < 5 && c < 40) begin
      out_ready = pat[c % 4];
      drive(sent < 5, 2'b00, (sent + 1) * 10, sent + 1, 1);
      #1;
      if (stalled) begin
        chk("bp_hold_valid", out_valid, 1);
        chk("bp_hold_sum", sum, held_sum);
        chk("bp_hold_ovf", ovf, held_ovf);
      end
      chk("bp_in_ready", in_ready, !((sent - got) == 2 && !out_ready));
      if (out_valid && out_ready) begin
        chk("bp_sum", $signed(sum), (got + 1) * 11);
        got++;
      end
      stalled = out_valid && !out_ready;
      held_sum = sum;
      held_ovf = ovf;
      if (in_valid && in_ready) sent++;
      @(posedge clk);
      #1;
      c++;
    end
    chk("bp_delivered", got, 5);
    in_valid = 1'b0;
    out_ready = 1'b1;
    tick;
    chk("bp_no_dup", out_valid, 0);
    // reset mid-stream
    drive(1, 2'b10, 9, 0, 1); tick;
    drive(1, 2'b00, 2, 2, 1); tick;
    drive(1, 2'b00, 3, 3, 1);
    chk("mid_pre_acc", $signed(acc), 9);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_out_valid", out_valid, 0);
    chk("mid_sum", sum, 0);
    chk("mid_ovf", ovf, 0);
    chk("mid_acc", acc, 0);
    in_valid = 1'b0;
    tick;
    rst_n = 1'b1;
    tick;
    chk("mid_in_ready", in_ready, 1);
    repeat (3) begin
      tick;
      chk("mid_no_stale", out_valid, 0);
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/signed_acc_adder.md
Name: signed_acc_adder

Overview:
- Parametrised, pipelined signed add/subtract/accumulate unit; successor to the fixed 8-bit combinational signed adder.
- Adds configurable operand/result widths, a runtime saturate/wrap mode, an overflow flag, an internal accumulator and valid/ready flow control.
- Sits between the multiplier output and the MAC result register; also usable as a standalone registered signed adder.

Parameters:
- WIDTH, 8: operand width (two's complement).
- ACC_WIDTH, 16: result and accumulator width; must be >= WIDTH+1.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  operand beat valid.
- in_ready  output  1  unit can accept a beat this cycle.
- a  input  WIDTH  signed operand A.
- b  input  WIDTH  signed operand B.
- op  input  2  00 ADD (a+b), 01 SUB (a-b), 10 ACC (acc+a; b ignored), 11 CLR (acc<=0).
- sat_en  input  1  1: saturate on overflow; 0: wrap (truncate).
- out_valid  output  1  result beat valid.
- out_ready  input  1  downstream accepts result.
- sum  output  ACC_WIDTH  signed result.
- ovf  output  1  result overflowed ACC_WIDTH (saturated or wrapped).
- acc  output  ACC_WIDTH  current accumulator value.

Behaviour:
- Reset (async assert, sync release): s1_valid=0, s2_valid=0, out_valid=0, sum=0, ovf=0, acc=0. in_ready=1 in the first cycle after release. In-flight beats are discarded.
- Two stages: S1 registers a, b, op and sat_en. S2 computes and registers sum/ovf and updates acc.
- Latency: exactly 2 cycles from input handshake to out_valid when not stalled.
- Handshakes: input fires on in_valid&in_ready; output fires on out_valid&out_ready.
- Stall logic: adv2 = !s2_valid | out_ready; adv1 = !s1_valid | (adv2). in_ready = adv1 (combinational, no dependency on in_valid).
- Hold rule: while out_valid=1 and out_ready=0, sum, ovf and out_valid hold stable. S1 holds its beat.
- Full throughput: one beat per cycle when out_ready=1 continuously.
- Arithmetic:
  - Operands are sign-extended to ACC_WIDTH+1 and the exact result r is formed.
  - ADD r=a+b; SUB r=a-b; ACC r=acc+a.
  - Overflow when r > 2^(ACC_WIDTH-1)-1 or r < -2^(ACC_WIDTH-1).
  - On overflow with sat_en=1: clamp to max/min, ovf=1.
  - On overflow with sat_en=0: low ACC_WIDTH bits, ovf=1.
  - Otherwise ovf=0.
- Accumulator:
  - Updated only when an ACC or CLR beat advances into S2. ACC: acc <= clamped/wrapped r, sum = new acc. CLR: acc <= 0, sum = 0, ovf = 0.
  - ADD/SUB never modify acc.
  - Back-to-back ACC beats use the acc updated by the previous beat (no hazard; the update occurs in S2 in order).
- Mode sampling: sat_en is captured per beat in S1. Changing it mid-stream affects only later beats.
- Simultaneous S2 output fire and new S2 load: the new beat replaces the old one in the same cycle, with no bubble.
- out_valid and the acc/sum registers never change on a cycle where S2 is stalled.

Test Plan:
- Reset mid-stream: issue 3 ADD beats, assert rst_n=0 after 1 cycle -> out_valid, sum, ovf and acc all 0 immediately; no stale beat appears after release; in_ready=1.
- Latency/throughput (defaults, out_ready=1): ADD a=100,b=27 then SUB a=-128,b=1 on consecutive cycles -> sum=127 at cycle 2, then sum=-129 at cycle 3, ovf=0 for both.
- Saturate (WIDTH=8, ACC_WIDTH=9, sat_en=1): CLR, then ACC a=127 x3 -> sums 127, 254, 255; ovf=0,0,1; acc=255. Then ACC a=-128 -> sum=127, ovf=0.
- Wrap (same params, sat_en=0): CLR, then ACC a=127 x3 -> third sum=-131, ovf=1. ADD a=-128,b=-128 -> sum=-256, ovf=0.
- Backpressure: stream 5 ADD beats with out_ready toggling 1,0,0,1,... -> in_ready drops within the cycle once both stages are full; sum/ovf stable while stalled; all 5 results delivered in order with no loss or duplication.
- Mixed ops: ACC a=5, ADD a=3,b=4, ACC a=-2, CLR back-to-back -> sums 5, 7, 3, 0; acc after each = 5, 5, 3, 0.
